sync_fifo_flex: RTL and testbench
=================================

Name: sync_fifo_flex

Overview:
- Parametrised single-clock FIFO; next-generation companion to the dual-clock FIFO, used where producer and consumer share one domain (e.g. SYS_CTRL to UART_TX frame buffering).
- Adds configurable depth and width, almost-full/almost-empty thresholds, and an occupancy count.
- Adds standard or first-word-fall-through (FWFT) read mode, sticky overflow/underflow error flags, and a synchronous clear.

Parameters:
- DATA_WIDTH, 8, data word width in bits.
- DEPTH, 8, number of entries; power of two, >= 2.
- AF_LEVEL, DEPTH-1, ALMOST_FULL asserts when COUNT >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- CLK  input  1  single clock; all logic rising-edge.
- RST  input  1  asynchronous, active-low reset.
- CLR  input  1  synchronous clear of pointers, count, flags.
- WR_EN  input  1  push request.
- WR_DATA  input  DATA_WIDTH  push data.
- RD_EN  input  1  pop request.
- RD_DATA  output  DATA_WIDTH  read data.
- RD_VALID  output  1  RD_DATA qualifier.
- FULL  output  1  COUNT == DEPTH.
- EMPTY  output  1  COUNT == 0.
- ALMOST_FULL  output  1  COUNT >= AF_LEVEL.
- ALMOST_EMPTY  output  1  COUNT <= AE_LEVEL.
- COUNT  output  $clog2(DEPTH)+1  current occupancy.
- OVERFLOW  output  1  sticky: write dropped.
- UNDERFLOW  output  1  sticky: read rejected.

Behaviour:
- Reset (RST=0, asynchronous):
  - Pointers = 0, COUNT = 0, EMPTY = 1, FULL = 0, ALMOST_EMPTY = 1, ALMOST_FULL = 0.
  - RD_DATA = 0, RD_VALID = 0, OVERFLOW = 0, UNDERFLOW = 0.
  - Memory contents are not reset.
- Accept rules:
  - wr_ok = WR_EN & (~FULL | rd_ok).
  - rd_ok = RD_EN & ~EMPTY.
  - A push into an empty FIFO in the same cycle as RD_EN is accepted; the read is rejected.
- Pointers and count:
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - COUNT is a registered counter: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Flags:
  - FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY are decoded combinationally from the registered COUNT.
  - They therefore change in the cycle after the accepting edge.
- Standard mode (FWFT=0):
  - On rd_ok, RD_DATA is registered with mem[rptr] at the same edge; data is visible one cycle after RD_EN.
  - RD_VALID is a one-cycle pulse coincident with the new RD_DATA.
  - RD_DATA holds its value between reads.
- FWFT mode (FWFT=1):
  - RD_DATA = mem[rptr] combinationally; RD_VALID = ~EMPTY.
  - RD_EN acknowledges and pops the presented word.
  - The first word appears the cycle after it is written.
- Sticky errors:
  - OVERFLOW is set when WR_EN & ~wr_ok.
  - UNDERFLOW is set when RD_EN & EMPTY.
  - Both hold until CLR or reset.
- CLR:
  - Has priority over WR_EN and RD_EN in the same cycle; neither is accepted.
  - Next state: pointers = 0, COUNT = 0, errors = 0, RD_VALID = 0.
  - RD_DATA holds in standard mode.
- Parameter checks: an elaboration-time error is raised for non-power-of-two DEPTH or out-of-range AF_LEVEL/AE_LEVEL.

Decomposition:
- parameters_pkg additions:
  - Default constants FIFO_DATA_WIDTH and FIFO_DEPTH.
  - Derived FIFO_PTR_WIDTH = $clog2(FIFO_DEPTH).
  - FIFO_CNT_WIDTH = FIFO_PTR_WIDTH + 1.
- Sub-module sync_fifo_mem: DEPTH x DATA_WIDTH register array with synchronous write port and combinational read port.
- Control (pointers, counter, flags, read register) stays in the top module.

Test Plan:
All scenarios use DATA_WIDTH=8, DEPTH=8, AF_LEVEL=7, AE_LEVEL=1 unless stated.
1. Reset: drive RST=0 mid-traffic with COUNT=3 -> immediately COUNT=0, EMPTY=1, ALMOST_EMPTY=1, RD_VALID=0, RD_DATA=0x00, OVERFLOW=0.
2. Fill and overflow, then drain:
   - Push 0x10..0x17 -> ALMOST_FULL=1 after the 7th push; FULL=1 and COUNT=8 after the 8th.
   - A 9th push of 0xFF -> OVERFLOW=1, COUNT stays 8.
   - Drain (FWFT=0) -> RD_DATA = 0x10..0x17, each with a one-cycle RD_VALID pulse one cycle after RD_EN; 0xFF is never returned.
3. Wrap-around: push 5 words, pop 5, push 0x20..0x27, pop 8 -> data returned in order 0x20..0x27 across the pointer wrap; EMPTY=1 at the end.
4. Simultaneous events:
   - At FULL, push 0x30 with pop -> pop returns 0x10, COUNT stays 8, OVERFLOW stays 0.
   - At EMPTY, push 0x40 with pop -> COUNT=1, UNDERFLOW=1, no RD_VALID pulse.
5. FWFT=1: push 0xA5 at cycle N -> at N+1, RD_VALID=1 and RD_DATA=0xA5 without RD_EN; RD_EN at N+1 -> at N+2, EMPTY=1 and RD_VALID=0.
6. CLR: with COUNT=5 and OVERFLOW=1, assert CLR together with WR_EN=1 -> next cycle COUNT=0, EMPTY=1, OVERFLOW=0, and the written word is discarded.

Source files
------------

// File: rtl/sync_fifo_flex_pkg.sv
// Shared defaults and helpers for the single-clock flexible FIFO.
package sync_fifo_flex_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 8;
    localparam int FIFO_PTR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_WIDTH  = FIFO_PTR_WIDTH + 1;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_flex_mem.sv
// Register-array storage: synchronous write port, combinational read port.
module sync_fifo_flex_mem
    import sync_fifo_flex_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    // Storage is deliberately not reset; stale words are never exposed as valid.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with configurable depth/width, threshold flags, occupancy
// count, standard or first-word-fall-through read, sticky errors and sync clear.
module sync_fifo_flex
    import sync_fifo_flex_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter bit FWFT       = 1'b0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CLR,
    input  logic                    WR_EN,
    input  logic [DATA_WIDTH-1:0]   WR_DATA,
    input  logic                    RD_EN,
    output logic [DATA_WIDTH-1:0]   RD_DATA,
    output logic                    RD_VALID,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic                    ALMOST_FULL,
    output logic                    ALMOST_EMPTY,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_flex: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_flex: AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_flex: AE_LEVEL must lie in 0..DEPTH-1");
    end

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         count;
    logic                  ovf;
    logic                  udf;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // Handshake: a push is accepted on WR_EN unless FULL, where a same-cycle
    // accepted pop frees the slot; a pop is accepted on RD_EN when not EMPTY.
    // Rejected requests change nothing except the sticky error flags.
    assign rd_ok = RD_EN & ~EMPTY;
    assign wr_ok = WR_EN & (~FULL | rd_ok);

    assign EMPTY        = (count == '0);
    assign FULL         = (count == CW'(DEPTH));
    assign ALMOST_FULL  = (count >= CW'(AF_LEVEL));
    assign ALMOST_EMPTY = (count <= CW'(AE_LEVEL));
    assign COUNT        = count;
    assign OVERFLOW     = ovf;
    assign UNDERFLOW    = udf;

    sync_fifo_flex_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (CLK),
        .wr_en   (wr_ok & ~CLR),
        .wr_addr (wptr),
        .wr_data (WR_DATA),
        .rd_addr (rptr),
        .rd_data (mem_rd_data)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (CLR) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (WR_EN & ~wr_ok) begin
                ovf <= 1'b1;
            end
            if (RD_EN & EMPTY) begin
                udf <= 1'b1;
            end
        end
    end

    if (FWFT) begin : g_fwft
        // Head word is presented directly; forced to zero while nothing is held.
        assign RD_VALID = ~EMPTY;
        assign RD_DATA  = EMPTY ? '0 : mem_rd_data;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (CLR) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_ok;
                if (rd_ok) begin
                    rd_data_q <= mem_rd_data;
                end
            end
        end

        assign RD_VALID = rd_valid_q;
        assign RD_DATA  = rd_data_q;
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a standard-mode and an FWFT instance share stimulus
// and are checked against a queue-based model, a vector table and corner sequences.
module tb_sync_fifo_flex;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 7;
    localparam int AE    = 1;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic          s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae;
    logic [CW-1:0] s_count, f_count;
    logic          s_ovf, f_ovf, s_udf, f_udf;

    // clock / reset
    always #5 clk = ~clk;

    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)) u_std (
        .CLK(clk), .RST(rst_n), .CLR(clr), .WR_EN(wr_en), .WR_DATA(wr_data), .RD_EN(rd_en),
        .RD_DATA(s_rd_data), .RD_VALID(s_rd_valid), .FULL(s_full), .EMPTY(s_empty),
        .ALMOST_FULL(s_af), .ALMOST_EMPTY(s_ae), .COUNT(s_count),
        .OVERFLOW(s_ovf), .UNDERFLOW(s_udf)
    );

    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)) u_fwft (
        .CLK(clk), .RST(rst_n), .CLR(clr), .WR_EN(wr_en), .WR_DATA(wr_data), .RD_EN(rd_en),
        .RD_DATA(f_rd_data), .RD_VALID(f_rd_valid), .FULL(f_full), .EMPTY(f_empty),
        .ALMOST_FULL(f_af), .ALMOST_EMPTY(f_ae), .COUNT(f_count),
        .OVERFLOW(f_ovf), .UNDERFLOW(f_udf)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [DW-1:0] exp_q[$];
    bit            m_ovf, m_udf, m_vld;
    logic [DW-1:0] m_rdata;

    typedef struct {
        bit            wr;
        bit            rd;
        logic [DW-1:0] d;
        int            e_count;
        bit            e_af;
        bit            e_full;
        bit            e_ovf;
        bit            e_udf;
        bit            e_vld;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_vld   = 1'b0;
        m_rdata = '0;
    endtask

    // One clock edge of FIFO behaviour, expressed as queue operations.
    task automatic model_edge();
        bit was_empty, was_full, rd, wr;
        if (clr) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_vld = 1'b0;
        end else begin
            was_empty = (exp_q.size() == 0);
            was_full  = (exp_q.size() == DEPTH);
            rd = rd_en && !was_empty;
            wr = wr_en && (!was_full || rd);
            if (wr_en && !wr) m_ovf = 1'b1;
            if (rd_en && was_empty) m_udf = 1'b1;
            m_vld = rd;
            if (rd) m_rdata = exp_q.pop_front();
            if (wr) exp_q.push_back(wr_data);
        end
    endtask

    task automatic check_model();
        int n;
        n = exp_q.size();
        chk("std_count", s_count, n);
        chk("std_empty", s_empty, n == 0);
        chk("std_full", s_full, n == DEPTH);
        chk("std_almost_full", s_af, n >= AF);
        chk("std_almost_empty", s_ae, n <= AE);
        chk("std_overflow", s_ovf, m_ovf);
        chk("std_underflow", s_udf, m_udf);
        chk("std_rd_valid", s_rd_valid, m_vld);
        chk("std_rd_data", s_rd_data, m_rdata);
        chk("fwft_count", f_count, n);
        chk("fwft_overflow", f_ovf, m_ovf);
        chk("fwft_underflow", f_udf, m_udf);
        chk("fwft_rd_valid", f_rd_valid, n != 0);
        if (n != 0) chk("fwft_rd_data", f_rd_data, exp_q[0]);
    endtask

    // driver: apply inputs, take one edge, check shortly after it
    task automatic cycle(input bit c, input bit w, input bit r, input logic [DW-1:0] d);
        clr     = c;
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        rst_n = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count", s_count, 0);
        chk("rst_empty", s_empty, 1);
        chk("rst_almost_empty", s_ae, 1);
        chk("rst_full", s_full, 0);
        chk("rst_rd_data", s_rd_data, 0);
        chk("rst_rd_valid", s_rd_valid, 0);
        #10 rst_n = 1'b1;

        // fill past full, overflow, drain, underflow
        for (int i = 0; i < DEPTH; i++)
            tbl.push_back('{1'b1, 1'b0, 8'(8'h10 + i), i + 1, (i + 1) >= AF, (i + 1) == DEPTH,
                            1'b0, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 8'hFF, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 8'h00, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10});
        for (int i = 1; i < DEPTH; i++)
            tbl.push_back('{1'b0, 1'b1, 8'h00, 7 - i, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'(8'h10 + i)});
        tbl.push_back('{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h17});

        foreach (tbl[k]) begin
            cycle(1'b0, tbl[k].wr, tbl[k].rd, tbl[k].d);
            chk("tbl_count", s_count, tbl[k].e_count);
            chk("tbl_almost_full", s_af, tbl[k].e_af);
            chk("tbl_full", s_full, tbl[k].e_full);
            chk("tbl_overflow", s_ovf, tbl[k].e_ovf);
            chk("tbl_underflow", s_udf, tbl[k].e_udf);
            chk("tbl_rd_valid", s_rd_valid, tbl[k].e_vld);
            chk("tbl_rd_data", s_rd_data, tbl[k].e_rdata);
        end

        // push and pop together while full
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        cycle(1'b0, 1'b1, 1'b1, 8'h30);
        chk("full_pushpop_data", s_rd_data, 8'h10);
        chk("full_pushpop_count", s_count, 8);
        chk("full_pushpop_ovf", s_ovf, 0);

        // clear beats a same-cycle write
        cycle(1'b0, 1'b1, 1'b0, 8'hEE);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
        chk("pre_clr_count", s_count, 5);
        chk("pre_clr_ovf", s_ovf, 1);
        cycle(1'b1, 1'b1, 1'b0, 8'h99);
        chk("clr_count", s_count, 0);
        chk("clr_empty", s_empty, 1);
        chk("clr_ovf", s_ovf, 0);
        chk("clr_fwft_valid", f_rd_valid, 0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk("clr_discard_count", s_count, 0);

        // push and pop together while empty
        cycle(1'b0, 1'b1, 1'b1, 8'h40);
        chk("empty_pushpop_count", s_count, 1);
        chk("empty_pushpop_udf", s_udf, 1);
        chk("empty_pushpop_vld", s_rd_valid, 0);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        chk("empty_pushpop_data", s_rd_data, 8'h40);

        // pointer wrap
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            chk("wrap_rd_data", s_rd_data, 8'(8'h20 + i));
            chk("wrap_rd_valid", s_rd_valid, 1);
        end
        chk("wrap_empty", s_empty, 1);

        // FWFT first-word latency and pop
        cycle(1'b0, 1'b1, 1'b0, 8'hA5);
        chk("fwft_first_valid", f_rd_valid, 1);
        chk("fwft_first_data", f_rd_data, 8'hA5);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fwft_pop_empty", f_empty, 1);
        chk("fwft_pop_valid", f_rd_valid, 0);

        // asynchronous reset mid-traffic
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h63);
        chk("pre_rst_count", s_count, 3);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_count", s_count, 0);
        chk("midrst_empty", s_empty, 1);
        chk("midrst_almost_empty", s_ae, 1);
        chk("midrst_rd_valid", s_rd_valid, 0);
        chk("midrst_rd_data", s_rd_data, 8'h00);
        chk("midrst_ovf", s_ovf, 0);
        chk("midrst_fwft_count", f_count, 0);
        rst_n = 1'b1;

        // randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 800; i++) begin
            int pw;
            pw = ((i / 100) % 2 == 0) ? 75 : 25;
            cycle($urandom_range(0, 59) == 0,
                  $urandom_range(0, 99) < pw,
                  $urandom_range(0, 99) < (100 - pw),
                  8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
